// File: rtl/sha_disp_pkg.sv
// Shared types and sizing for the SHA display path.
// Used by the word bank loader and the switch-selected word mux.
package sha_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } loader_state_t;

  localparam int NUM_WORDS = 8;
  localparam int SLOT_W    = 3;

endpackage

// File: rtl/word_bank_loader.sv
// Fills eight registered words a..h in order, one per valid/ready handshake.
// The bank then freezes until the next start pulse.
module word_bank_loader
  import sha_disp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   f,
  output logic [WIDTH-1:0]   g,
  output logic [WIDTH-1:0]   h,
  output logic [SLOT_W-1:0]  slot,
  output logic               full
);

  loader_state_t           state;
  logic [WIDTH-1:0]        bank [NUM_WORDS];
  logic [SLOT_W-1:0]       slot_q;

  // start wins over a same-cycle transfer, so the word offered with it is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      slot_q <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= '0;
      end
    end else if (start) begin
      state  <= FILL;
      slot_q <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= '0;
      end
    end else if ((state == FILL) && in_valid) begin
      bank[slot_q] <= in_data;
      slot_q       <= slot_q + 3'd1;
      if (slot_q == 3'd7) begin
        state <= FULL;
      end
    end
  end

  assign in_ready = (state == FILL);
  assign full     = (state == FULL);
  assign slot     = slot_q;

  assign a = bank[0];
  assign b = bank[1];
  assign c = bank[2];
  assign d = bank[3];
  assign e = bank[4];
  assign f = bank[5];
  assign g = bank[6];
  assign h = bank[7];

endmodule

// File: tb/tb_word_bank_loader.sv
// Directed bench for word_bank_loader: stimulus pushes expected transfers into a
// scoreboard queue that a separate monitor drains on every accepted handshake.
module tb_word_bank_loader;
  import sha_disp_pkg::*;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [WIDTH-1:0]  a, b, c, d, e, f, g, h;
  logic [2:0]        slot;
  logic              full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  slot;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_bank[8];
  logic [31:0] sha_iv[8];

  word_bank_loader #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .slot     (slot),
    .full     (full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bank_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return a;
      3'd1:    return b;
      3'd2:    return c;
      3'd3:    return d;
      3'd4:    return e;
      3'd5:    return f;
      3'd6:    return g;
      default: return h;
    endcase
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge
  task automatic applyStimulus(input logic s, input logic v, input logic [31:0] dat);
    @(negedge clk);
    start    = s;
    in_valid = v;
    in_data  = dat;
  endtask

  task automatic checkOutput(input string tag, input logic exp_full,
                             input logic exp_ready, input logic [2:0] exp_slot);
    for (int i = 0; i < 8; i++) begin
      compare($sformatf("%s_word%0d", tag, i), bank_word(3'(i)), exp_bank[i]);
    end
    compare({tag, "_full"},  {31'd0, full},     {31'd0, exp_full});
    compare({tag, "_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    compare({tag, "_slot"},  {29'd0, slot},     {29'd0, exp_slot});
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) exp_bank[i] = 32'd0;
  endtask

  task automatic sendWord(input logic [2:0] idx, input logic [31:0] w);
    exp_t item;
    item.slot = idx;
    item.word = w;
    sb_q.push_back(item);
    exp_bank[idx] = w;
    applyStimulus(1'b0, 1'b1, w);
  endtask

  // Monitor: every accepted handshake must match the next queued expectation
  initial begin
    logic [2:0] s;
    exp_t       item;
    forever begin
      @(posedge clk);
      if (!reset && !start && in_valid && in_ready) begin
        s = slot;
        #1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_xfer actual=slot%0d required=no_transfer", s);
        end else begin
          item = sb_q.pop_front();
          compare("xfer_slot", {29'd0, s}, {29'd0, item.slot});
          compare("xfer_word", bank_word(item.slot), item.word);
          compare("xfer_next_slot", {29'd0, slot}, {29'd0, 3'(item.slot + 3'd1)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sha_iv[0] = 32'h6A09E667; sha_iv[1] = 32'hBB67AE85;
    sha_iv[2] = 32'h3C6EF372; sha_iv[3] = 32'hA54FF53A;
    sha_iv[4] = 32'h510E527F; sha_iv[5] = 32'h9B05688C;
    sha_iv[6] = 32'h1F83D9AB; sha_iv[7] = 32'h5BE0CD19;
    clearModel();

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    checkOutput("reset", 1'b0, 1'b0, 3'd0);

    // Idle must ignore offered words
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("idle", 1'b0, 1'b0, 3'd0);

    $display("[TB] back-to-back fill");
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sendWord(3'(i), sha_iv[i]);
      if (i == 7) begin
        compare("pre_full_full",  {31'd0, full},     32'd0);
        compare("pre_full_ready", {31'd0, in_ready}, 32'd1);
        compare("pre_full_slot",  {29'd0, slot},     32'd7);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("fill1", 1'b1, 1'b0, 3'd0);

    $display("[TB] toggled-valid fill");
    applyStimulus(1'b1, 1'b0, 32'd0);
    clearModel();
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) sendWord(3'(k / 2), sha_iv[k / 2]);
      else applyStimulus(1'b0, 1'b0, 32'h0BAD0BAD);
      compare($sformatf("toggle_full_c%0d", k), {31'd0, full}, (k >= 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("fill2", 1'b1, 1'b0, 3'd0);

    $display("[TB] hold while full, then restart");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("full_hold", 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    clearModel();
    checkOutput("restart", 1'b0, 1'b1, 3'd0);

    $display("[TB] reset mid-fill");
    sendWord(3'd0, 32'h1);
    sendWord(3'd1, 32'h2);
    sendWord(3'd2, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("partial", 1'b0, 1'b1, 3'd3);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    clearModel();
    checkOutput("mid_reset", 1'b0, 1'b0, 3'd0);

    $display("[TB] start with same-cycle valid");
    applyStimulus(1'b1, 1'b0, 32'd0);
    sendWord(3'd0, 32'hA);
    sendWord(3'd1, 32'hB);
    sendWord(3'd2, 32'hC);
    applyStimulus(1'b1, 1'b1, 32'hCAFE0000);
    applyStimulus(1'b0, 1'b0, 32'd0);
    clearModel();
    checkOutput("start_drop", 1'b0, 1'b1, 3'd0);
    sendWord(3'd0, 32'h11);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("after_drop", 1'b0, 1'b1, 3'd1);

    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    compare("sb_drain", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
